// File: rtl/consumer_pkg.sv
// consumer_pkg: shared state encoding and widths for the fifo_consumer slice
package consumer_pkg;
    typedef enum logic {IDLE, CAPTURE} cons_state_e;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int RD_CNT_W = 16;
endpackage

// File: rtl/consumer_rise_det.sv
// consumer_rise_det: registers rd_req and flags its 0->1 transition
module consumer_rise_det (
    input  logic r_clk,
    input  logic rrst,
    input  logic rd_req,
    output logic req_rise
);
    logic rd_req_q;
    logic rd_req_d;
    always_comb begin
        rd_req_d = rd_req;
        req_rise = rd_req & ~rd_req_q;
    end
    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) rd_req_q <= 1'b0;
        else       rd_req_q <= rd_req_d;
    end
endmodule

// File: rtl/fifo_consumer.sv
// fifo_consumer: one FIFO pop per rd_req rise, captures read data a cycle later; CONSUMER_RD_CNT_EN adds rd_cnt
module fifo_consumer
    import consumer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  r_clk,
    input  logic                  rrst,
    input  logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  f_empty,
    output logic                  r_en,
`ifdef CONSUMER_RD_CNT_EN
    output logic [RD_CNT_W-1:0]   rd_cnt,
`endif
    output logic [DATA_WIDTH-1:0] data_out
);
    cons_state_e           state_q, state_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  req_rise;

    consumer_rise_det u_rise (
        .r_clk    (r_clk),
        .rrst     (rrst),
        .rd_req   (rd_req),
        .req_rise (req_rise)
    );

    always_comb begin
        r_en       = (state_q == IDLE) & pend_q & ~f_empty;
        pend_d     = req_rise | (pend_q & ~r_en);
        state_d    = r_en ? CAPTURE : IDLE;
        data_out_d = (state_q == CAPTURE) ? mem_data_out : data_out_q;
    end

    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

`ifdef CONSUMER_RD_CNT_EN
    logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    always_comb rd_cnt_d = rd_cnt_q + RD_CNT_W'(state_q == CAPTURE);
    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) rd_cnt_q <= '0;
        else       rd_cnt_q <= rd_cnt_d;
    end
    assign rd_cnt = rd_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_consumer.sv
// tb_fifo_consumer: random scoreboard bench for fifo_consumer (CONSUMER_RD_CNT_EN optional)
module tb_fifo_consumer;
    logic        r_clk = 1'b0;
    logic        rrst;
    logic        rd_req;
    logic [31:0] mem_data_out;
    logic        f_empty;
    logic        r_en;
    logic [31:0] data_out;
`ifdef CONSUMER_RD_CNT_EN
    logic [15:0] rd_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] mem_q[$];
    logic [31:0] exp_q[$];

    fifo_consumer #(.DATA_WIDTH(32)) dut (
        .r_clk        (r_clk),
        .rrst         (rrst),
        .rd_req       (rd_req),
        .mem_data_out (mem_data_out),
        .f_empty      (f_empty),
        .r_en         (r_en),
`ifdef CONSUMER_RD_CNT_EN
        .rd_cnt       (rd_cnt),
`endif
        .data_out     (data_out)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a request is owed after each rd_req rise, paid in the first
    // non-empty cycle that does not directly follow a previous pop.
    logic        m_pend = 1'b0;
    logic        m_prev = 1'b0;
    logic        m_cap = 1'b0;
    logic        nxt_cap;
    logic        exp_ren;
    logic        do_mem;
    logic [31:0] exp_data = '0;
    logic [15:0] m_cnt = '0;

    initial begin
        forever begin
            @(negedge r_clk);
            #4;
            if (!rrst) begin
                chk("r_en_in_reset", {31'b0, r_en}, 32'd0);
                m_pend = 1'b0;
                m_prev = 1'b0;
                m_cap = 1'b0;
                nxt_cap = 1'b0;
                do_mem = 1'b0;
                exp_q.delete();
                exp_data = '0;
                m_cnt = '0;
            end else begin
                exp_ren = m_pend && !f_empty && !m_cap;
                chk("r_en", {31'b0, r_en}, {31'b0, exp_ren});
                nxt_cap = exp_ren;
                if (exp_ren) m_pend = 1'b0;
                if (rd_req && !m_prev) m_pend = 1'b1;
                m_prev = rd_req;
                do_mem = r_en;
            end
            @(posedge r_clk);
            #1;
            if (do_mem) begin
                mem_data_out = (mem_q.size() != 0) ? mem_q.pop_front() : $urandom;
                exp_q.push_back(mem_data_out);
            end else begin
                mem_data_out = $urandom;
            end
            if (m_cap) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow at %0t: capture with no popped word", $time);
                end else begin
                    exp_data = exp_q.pop_front();
                end
                m_cnt = m_cnt + 16'd1;
            end
            chk("data_out", data_out, exp_data);
`ifdef CONSUMER_RD_CNT_EN
            chk("rd_cnt", {16'b0, rd_cnt}, {16'b0, m_cnt});
`endif
            m_cap = nxt_cap;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge r_clk);
    endtask

    initial begin
        rrst = 1'b0;
        rd_req = 1'b0;
        f_empty = 1'b0;
        mem_data_out = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            rd_req = ~rd_req;
            #1;
            chk("data_out_in_reset", data_out, 32'd0);
        end
        @(negedge r_clk);
        rd_req = 1'b0;
        rrst = 1'b1;
        cycles(4);

        mem_q.push_back(32'hDEADBEEF);
        rd_req = 1'b1;
        cycles(3);
        rd_req = 1'b0;
        cycles(3);

        f_empty = 1'b1;
        rd_req = 1'b1;
        cycles(1);
        rd_req = 1'b0;
        cycles(5);
        f_empty = 1'b0;
        cycles(4);

        for (int i = 0; i < 100; i++) begin
            f_empty = ($urandom_range(3) == 0);
            rd_req = 1'b1;
            cycles($urandom_range(3, 1));
            rd_req = 1'b0;
            cycles($urandom_range(3, 1));
        end
        f_empty = 1'b0;
        cycles(4);

        rd_req = 1'b1;
        cycles(1);
        rd_req = 1'b0;
        cycles(1);
        rd_req = 1'b1;
        cycles(2);
        rd_req = 1'b0;
        cycles(4);

        rd_req = 1'b1;
        cycles(2);
        #2;
        rrst = 1'b0;
        #1;
        chk("data_out_async_reset", data_out, 32'd0);
`ifdef CONSUMER_RD_CNT_EN
        chk("rd_cnt_async_reset", {16'b0, rd_cnt}, 32'd0);
`endif
        cycles(2);
        rrst = 1'b1;
        rd_req = 1'b0;
        cycles(4);
        rd_req = 1'b1;
        cycles(2);
        rd_req = 1'b0;
        cycles(4);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
